// File: rtl/prng_pkg.sv
// Shared types, default tap polynomials and the AES S-box function for the
// pseudo-random byte-stream generator.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 as a Fibonacci feedback mask
    localparam logic [15:0] FIB_TAPS_16 = 16'hB400;
    // x^16 + x^5 + x^3 + x^2 + 1, low terms only, for the Galois form
    localparam logic [15:0] GAL_TAPS_16 = 16'h002D;

    // GF(2^8) multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse as x^254 (zero maps to zero), then the
    // affine transform with constant 0x63
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Purely combinational AES S-box for one byte, expressed as GF(2^8) gate logic.
module aes_sbox
    import prng_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_byte(in_i);

endmodule

// File: rtl/prng_stream.sv
// Runtime-selectable Fibonacci/Galois LFSR whose serial output is gathered
// into words of 8*OUT_BYTES bits, optionally S-box whitened, and handed out
// on a valid/ready stream.
module prng_stream
    import prng_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          OUT_BYTES = 1,
    parameter logic [31:0] FIB_TAPS  = 32'(FIB_TAPS_16),
    parameter logic [31:0] GAL_TAPS  = 32'(GAL_TAPS_16)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   seed_valid,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   mode,
    input  logic                   whiten,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int N  = 8 * OUT_BYTES;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(N - 1);
    localparam logic [WIDTH-1:0] FIB_MASK  = FIB_TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] GAL_MASK  = GAL_TAPS[WIDTH-1:0];

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [N-1:0]     sipo_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic             whiten_q;
    logic             out_valid_q;
    logic [N-1:0]     out_data_q;
    logic             busy_q;

    logic [WIDTH-1:0] lfsr_d;
    logic [N-1:0]     sipo_d;
    logic [N-1:0]     sbox_word;
    logic [N-1:0]     word_d;
    logic             step_bit;

    // One LFSR step in the latched mode, and the SIPO contents after it
    always_comb begin
        step_bit = 1'b0;
        lfsr_d   = lfsr_q;
        if (mode_q) begin
            step_bit = lfsr_q[WIDTH-1];
            lfsr_d   = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? GAL_MASK : '0);
        end else begin
            step_bit = ^(lfsr_q & FIB_MASK);
            lfsr_d   = {lfsr_q[WIDTH-2:0], step_bit};
        end
        sipo_d = {sipo_q[N-2:0], step_bit};
    end

    // Each byte of the freshly completed word goes through its own S-box
    for (genvar k = 0; k < OUT_BYTES; k++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sipo_d[8*k +: 8]),
            .out_o (sbox_word[8*k +: 8])
        );
    end

    assign word_d = whiten_q ? sbox_word : sipo_d;

    // Control FSM with registered stream outputs; a seed request beats everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            sipo_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            whiten_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else if (seed_valid) begin
            lfsr_q      <= (seed == '0) ? WIDTH'(1) : seed;
            mode_q      <= mode;
            whiten_q    <= whiten;
            cnt_q       <= '0;
            sipo_q      <= '0;
            out_valid_q <= 1'b0;
            state_q     <= SHIFT;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                SHIFT: begin
                    lfsr_q <= lfsr_d;
                    sipo_q <= sipo_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        out_data_q  <= word_d;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                        busy_q      <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SHIFT;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prng_stream.sv
// Self-checking bench for prng_stream (WIDTH=16, OUT_BYTES=1) against a
// bit-serial arithmetic model of the LFSR rules and a table-built S-box.
module tb_prng_stream;

    localparam int unsigned TB_FIB  = 32'h0000_B400;
    localparam int unsigned TB_GAL  = 32'h0000_002D;
    localparam int unsigned TB_MASK = 32'h0000_FFFF;
    localparam int          BUDGET  = 40;

    logic        clock;
    logic        reset_n;
    logic        seed_valid;
    logic [15:0] seed;
    logic        mode;
    logic        whiten;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int errors;
    int checks;

    logic [7:0]  sboxTab [256];
    int unsigned mLfsr;
    bit          mMode;
    bit          mWhiten;

    prng_stream #(
        .WIDTH     (16),
        .OUT_BYTES (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .mode       (mode),
        .whiten     (whiten),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Carry-less multiply modulo 0x11B, done on plain integers
    function automatic int unsigned tb_gmul(input int unsigned a, input int unsigned b);
        int unsigned p;
        int unsigned aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 32'h100) != 0) aa = aa ^ 32'h11B;
        end
        return p;
    endfunction

    // S-box table: brute-force inverse, then the per-bit affine definition
    task automatic build_sbox();
        int unsigned inv;
        int unsigned s;
        int unsigned c;
        c = 32'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && tb_gmul(x, y) == 1) inv = y;
            end
            s = 0;
            for (int i = 0; i < 8; i++) begin
                s = s | (((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                        ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (c >> i)) & 1) << i;
            end
            sboxTab[x] = 8'(s);
        end
    endtask

    task automatic model_seed(input logic [15:0] s, input bit m, input bit w);
        mLfsr   = (s == 16'h0000) ? 1 : int'(s);
        mMode   = m;
        mWhiten = w;
    endtask

    // Next 8 serial bits of the stream, first bit in the MSB
    task automatic model_word(output logic [7:0] w);
        int unsigned v;
        int unsigned b;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            if (mMode) begin
                b     = (mLfsr >> 15) & 1;
                mLfsr = ((mLfsr << 1) & TB_MASK) ^ ((b != 0) ? TB_GAL : 0);
            end else begin
                b     = $countones(mLfsr & TB_FIB) % 2;
                mLfsr = ((mLfsr << 1) | b) & TB_MASK;
            end
            v = (v << 1) | b;
        end
        w = mWhiten ? sboxTab[v] : 8'(v);
    endtask

    // Called at a negedge: request a seed for one edge, then scramble mode/whiten
    task automatic seed_dut(input logic [15:0] s, input bit m, input bit w);
        seed_valid = 1'b1;
        seed       = s;
        mode       = m;
        whiten     = w;
        model_seed(s, m, w);
        @(negedge clock);
        seed_valid = 1'b0;
        seed       = 16'($urandom);
        mode       = 1'($urandom);
        whiten     = 1'($urandom);
    endtask

    // Wait (bounded) for the next word; waited counts edges since the seed/handshake edge
    task automatic get_word(input bit first, input bit readyWhileWaiting,
                            output logic [7:0] data, output int waited);
        if (!first) @(negedge clock);
        out_ready = readyWhileWaiting;
        waited = 1;
        while (out_valid !== 1'b1 && waited < BUDGET) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL word_timeout: out_valid=%b after %0d edges, required 1", out_valid, waited);
        end
        data = out_data;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        seed_valid = 1'b0;
        seed       = 16'h0000;
        mode       = 1'b0;
        whiten     = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h required 00", out_data); end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_quiet: valid=%b busy=%b required 0/0", out_valid, busy);
            end
        end
    endtask

    task automatic test_known_words(input string name, input bit m, input bit w,
                                    input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        seed_dut(16'h0001, m, w);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy: got %b required 1", name, busy); end
        get_word(1'b1, 1'b1, got, waited);
        model_word(exp);
        checks++;
        if (waited != 9) begin errors++; $display("[TB] FAIL %s_latency0: got %0d edges required 9", name, waited); end
        checks++;
        if (got !== w0 || got !== exp) begin
            errors++;
            $display("[TB] FAIL %s_word0: got %h required %h (model %h)", name, got, w0, exp);
        end
        get_word(1'b0, 1'b1, got, waited);
        model_word(exp);
        checks++;
        if (waited != 9) begin errors++; $display("[TB] FAIL %s_latency1: got %0d edges required 9", name, waited); end
        checks++;
        if (got !== w1 || got !== exp) begin
            errors++;
            $display("[TB] FAIL %s_word1: got %h required %h (model %h)", name, got, w1, exp);
        end
    endtask

    task automatic test_fib_seed_zero();
        logic [7:0] ref1 [4];
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        seed_dut(16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            get_word(i == 0, 1'b1, got, waited);
            model_word(exp);
            ref1[i] = got;
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL fib_word%0d: got %h required %h", i, got, exp); end
        end
        checks++;
        if (ref1[0] !== 8'h00) begin errors++; $display("[TB] FAIL fib_first: got %h required 00", ref1[0]); end
        @(negedge clock);
        seed_dut(16'h0000, 1'b0, 1'b0);
        model_seed(16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            get_word(i == 0, 1'b1, got, waited);
            model_word(exp);
            checks++;
            if (got !== ref1[i] || got !== exp) begin
                errors++;
                $display("[TB] FAIL seed0_word%0d: got %h required %h", i, got, exp);
            end
        end
    endtask

    // Random ready stalls, including a 20-cycle stall on the first word
    task automatic test_stall(input logic [15:0] s, input bit m, input bit w,
                              input int words, input int firstStall);
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        int stall;
        seed_dut(s, m, w);
        for (int i = 0; i < words; i++) begin
            get_word(i == 0, 1'b0, got, waited);
            model_word(exp);
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL stall_word%0d: got %h required %h", i, got, exp); end
            stall = (i == 0) ? firstStall : int'($urandom_range(0, 4));
            for (int c = 0; c < stall; c++) begin
                @(negedge clock);
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    errors++;
                    $display("[TB] FAIL stall_hold%0d: valid=%b data=%h required 1/%h", i, out_valid, out_data, exp);
                end
            end
            out_ready = 1'b1;
        end
    endtask

    task automatic test_reseed_mid_shift();
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        seed_dut(16'hBEEF, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        seed_dut(16'h5A5A, 1'b0, 1'b1);
        get_word(1'b1, 1'b1, got, waited);
        model_word(exp);
        checks++;
        if (waited != 9) begin errors++; $display("[TB] FAIL reseed_latency: got %0d edges required 9", waited); end
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL reseed_word: got %h required %h", got, exp); end
    endtask

    task automatic test_reseed_on_handshake();
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        seed_dut(16'h0001, 1'b1, 1'b0);
        get_word(1'b1, 1'b1, got, waited);
        seed_dut(16'h1234, 1'b0, 1'b1);
        get_word(1'b1, 1'b1, got, waited);
        model_word(exp);
        checks++;
        if (waited != 9) begin errors++; $display("[TB] FAIL hs_reseed_latency: got %0d edges required 9", waited); end
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL hs_reseed_word: got %h required %h", got, exp); end
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] got;
        logic [7:0] exp;
        int waited;
        int seen;
        seed_dut(16'h0001, 1'b1, 1'b1);
        get_word(1'b1, 1'b0, got, waited);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b busy=%b data=%h required 0/0/00", out_valid, busy, out_data);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL post_reset_idle: got %0d active cycles required 0", seen); end
        seed_dut(16'hC0DE, 1'b1, 1'b1);
        get_word(1'b1, 1'b1, got, waited);
        model_word(exp);
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL post_reset_word: got %h required %h", got, exp); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        build_sbox();
        test_reset();
        @(negedge clock);
        test_known_words("gal_plain", 1'b1, 1'b0, 8'h00, 8'h01);
        @(negedge clock);
        test_known_words("gal_white", 1'b1, 1'b1, 8'h63, 8'h7C);
        @(negedge clock);
        test_fib_seed_zero();
        @(negedge clock);
        test_stall(16'hACE1, 1'b1, 1'b0, 16, 20);
        @(negedge clock);
        test_stall(16'hACE1, 1'b1, 1'b0, 16, 0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clock);
            test_stall(16'($urandom), 1'($urandom), 1'($urandom), 6, int'($urandom_range(0, 3)));
        end
        @(negedge clock);
        test_reseed_mid_shift();
        @(negedge clock);
        test_reseed_on_handshake();
        @(negedge clock);
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
